// File: rtl/risc18_pkg.sv
// ============================================================================
// Module   : risc18_pkg
// Brief    : RISC18 opcodes, default pad word, packer FSM states, legality check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package risc18_pkg;

  localparam logic [3:0] c_OP_ADD = 4'b0000;
  localparam logic [3:0] c_OP_NDU = 4'b0010;
  localparam logic [3:0] c_OP_LW  = 4'b0100;
  localparam logic [3:0] c_OP_SW  = 4'b0101;
  localparam logic [3:0] c_OP_BEQ = 4'b0110;
  localparam logic [3:0] c_OP_JAL = 4'b1000;

  // Opcode F falls into the core's default path: PC advances, nothing else.
  localparam logic [15:0] c_PAD_WORD = 16'hF000;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_EMIT = 1'b1
  } pack_state_t;

  function automatic logic risc18_legal(input logic [3:0] op);
    case (op)
      c_OP_ADD, c_OP_NDU, c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_JAL: risc18_legal = 1'b1;
      default: risc18_legal = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/risc18_program_packer_if.sv
// ============================================================================
// Module   : risc18_program_packer_if
// Brief    : Instruction-beat input stream and program-image output stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface risc18_program_packer_if;

  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [2:0]  in_ra;
  logic [2:0]  in_rb;
  logic [2:0]  in_rc;
  logic [8:0]  in_imm;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_image;
  logic [2:0]  out_count;
  logic        err_illegal;

  modport slave (
    input  in_valid, in_opcode, in_ra, in_rb, in_rc, in_imm, in_last, out_ready,
    output in_ready, out_valid, out_image, out_count, err_illegal
  );

  modport master (
    output in_valid, in_opcode, in_ra, in_rb, in_rc, in_imm, in_last, out_ready,
    input  in_ready, out_valid, out_image, out_count, err_illegal
  );

endinterface

`default_nettype wire

// File: rtl/risc18_insn_encoder.sv
// ============================================================================
// Module   : risc18_insn_encoder
// Brief    : Combinational RISC18 field-to-word encoder with legality flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module risc18_insn_encoder
  import risc18_pkg::*;
(
  input  logic [3:0]  i_opcode,
  input  logic [2:0]  i_ra,
  input  logic [2:0]  i_rb,
  input  logic [2:0]  i_rc,
  input  logic [8:0]  i_imm,
  output logic [15:0] o_word,
  output logic        o_legal
);

  // Unknown opcodes fall through to the register-register layout.
  always_comb begin
    o_word = {i_opcode, i_ra, i_rb, i_rc, 3'b000};
    case (i_opcode)
      c_OP_LW, c_OP_SW, c_OP_BEQ: o_word = {i_opcode, i_ra, i_rb, i_imm[5:0]};
      c_OP_JAL:                   o_word = {i_opcode, i_ra, i_imm};
      default: ;
    endcase
  end

  assign o_legal = risc18_legal(i_opcode);

endmodule

`default_nettype wire

// File: rtl/risc18_program_packer.sv
// ============================================================================
// Module   : risc18_program_packer
// Brief    : Packs up to four encoded RISC18 instructions into a 64-bit image.
//            RISC18_PACK_OPCHECK_EN: replace illegal opcodes with PAD_WORD and
//            raise sticky err_illegal.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module risc18_program_packer
  import risc18_pkg::*;
#(
  parameter logic [15:0] PAD_WORD = c_PAD_WORD
)
(
  input  logic                      clock,
  input  logic                      reset,
  risc18_program_packer_if.slave    bus
);

`ifdef RISC18_PACK_OPCHECK_EN
  localparam bit c_OPCHECK = 1'b1;
`else
  localparam bit c_OPCHECK = 1'b0;
`endif

  pack_state_t r_state;
  pack_state_t w_state_next;
  logic [1:0]  r_idx;
  logic [63:0] r_image;
  logic [2:0]  r_count;
  logic        r_err;

  logic        w_ready;
  logic        w_valid;
  logic        w_accept;
  logic        w_handshake;
  logic        w_close;
  logic        w_legal;
  logic        w_drop;
  logic [15:0] w_enc_word;
  logic [15:0] w_slot_word;

  risc18_insn_encoder u_encoder (
    .i_opcode (bus.in_opcode),
    .i_ra     (bus.in_ra),
    .i_rb     (bus.in_rb),
    .i_rc     (bus.in_rc),
    .i_imm    (bus.in_imm),
    .o_word   (w_enc_word),
    .o_legal  (w_legal)
  );

  assign w_drop      = c_OPCHECK && !w_legal;
  assign w_slot_word = w_drop ? PAD_WORD : w_enc_word;

  // Decoded from the state register so ready never depends on out_ready.
  assign w_accept    = bus.in_valid && (r_state == ST_FILL);
  assign w_handshake = bus.out_ready && (r_state == ST_EMIT);
  assign w_close     = (r_idx == 2'd3) || bus.in_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_valid      = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_ready = 1'b1;
        if (w_accept && w_close) begin
          w_state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        w_valid = 1'b1;
        if (w_handshake) begin
          w_state_next = ST_FILL;
        end
      end
      default: w_state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx   <= 2'd0;
      r_image <= {4{PAD_WORD}};
      r_count <= 3'd0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      case (r_idx)
        2'd0:    r_image[63:48] <= w_slot_word;
        2'd1:    r_image[47:32] <= w_slot_word;
        2'd2:    r_image[31:16] <= w_slot_word;
        default: r_image[15:0]  <= w_slot_word;
      endcase
      if (w_close) begin
        r_count <= {1'b0, r_idx} + 3'd1;
      end else begin
        r_idx <= r_idx + 2'd1;
      end
      if (w_drop) begin
        r_err <= 1'b1;
      end
    end else if (w_handshake) begin
      r_idx   <= 2'd0;
      r_image <= {4{PAD_WORD}};
      r_count <= 3'd0;
    end
  end

  assign bus.in_ready    = w_ready;
  assign bus.out_valid   = w_valid;
  assign bus.out_image   = r_image;
  assign bus.out_count   = r_count;
  assign bus.err_illegal = r_err;

endmodule

`default_nettype wire

// File: tb/tb_risc18_program_packer.sv
// ============================================================================
// Module   : tb_risc18_program_packer
// Brief    : Directed and randomized checks of the RISC18 program packer
//            against a queue-based image model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_risc18_program_packer;

  localparam logic [15:0] c_PAD = 16'hF000;
`ifdef RISC18_PACK_OPCHECK_EN
  localparam bit c_OPCHECK = 1'b1;
`else
  localparam bit c_OPCHECK = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;

  risc18_program_packer_if bus ();

  risc18_program_packer #(.PAD_WORD(16'hF000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] m_words[$];
  bit          m_err = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_legal(input int op);
    return op == 0 || op == 2 || op == 4 || op == 5 || op == 6 || op == 8;
  endfunction

  function automatic logic [15:0] ref_encode(input int op, input int ra, input int rb,
                                             input int rc, input int imm);
    int w;
    w = op * 4096 + ra * 512;
    if (op == 4 || op == 5 || op == 6)   w = w + rb * 64 + (imm % 64);
    else if (op == 8)                    w = w + (imm % 512);
    else if (!ref_legal(op) && c_OPCHECK) w = int'(c_PAD);
    else                                 w = w + rb * 64 + rc * 8;
    return w[15:0];
  endfunction

  function automatic logic [63:0] ref_image();
    logic [63:0] img;
    img = 64'd0;
    for (int s = 0; s < 4; s++) begin
      img = (img << 16) | ((s < m_words.size()) ? {48'd0, m_words[s]} : {48'd0, c_PAD});
    end
    return img;
  endfunction

  task automatic send_beat(input int op, input int ra, input int rb, input int rc,
                           input int imm, input bit last);
    @(negedge clock);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op[3:0];
    bus.in_ra     = ra[2:0];
    bus.in_rb     = rb[2:0];
    bus.in_rc     = rc[2:0];
    bus.in_imm    = imm[8:0];
    bus.in_last   = last;
    for (int w = 0; w < 50 && !bus.in_ready; w++) @(negedge clock);
    if (!bus.in_ready) begin
      check_eq("in_ready_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    m_words.push_back(ref_encode(op, ra, rb, rc, imm));
    if (c_OPCHECK && !ref_legal(op)) m_err = 1'b1;
  endtask

  // Called 1 time unit after the closing beat's edge.
  task automatic expect_image(input string tag, input int hold, input bit use_const,
                              input logic [63:0] exp_const);
    logic [63:0] exp_img;
    exp_img = ref_image();
    check_eq({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
    check_eq({tag, "_ready"}, {63'd0, bus.in_ready}, 64'd0);
    check_eq({tag, "_img"}, bus.out_image, exp_img);
    check_eq({tag, "_cnt"}, {61'd0, bus.out_count}, 64'(m_words.size()));
    check_eq({tag, "_err"}, {63'd0, bus.err_illegal}, {63'd0, m_err});
    if (use_const) check_eq({tag, "_const"}, bus.out_image, exp_const);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check_eq({tag, "_hold"}, {bus.out_valid, bus.out_image[62:0]}, {1'b1, exp_img[62:0]});
    end
    @(negedge clock);
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    check_eq({tag, "_drain"}, {bus.in_ready, bus.out_valid, bus.out_count},
             {1'b1, 1'b0, 3'd0});
    check_eq({tag, "_clear"}, bus.out_image, {4{c_PAD}});
    m_words.delete();
  endtask

  initial begin
    logic [63:0] t4_exp;
    logic [63:0] held_img;
    bus.in_valid  = 1'b0;
    bus.in_opcode = 4'd0;
    bus.in_ra     = 3'd0;
    bus.in_rb     = 3'd0;
    bus.in_rc     = 3'd0;
    bus.in_imm    = 9'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("rst_hs", {bus.in_ready, bus.out_valid, bus.err_illegal, bus.out_count},
             {1'b1, 1'b0, 1'b0, 3'd0});
    check_eq("rst_img", bus.out_image, {4{c_PAD}});
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Full image
    send_beat(0, 2, 1, 2, 0, 1'b0);
    send_beat(6, 1, 2, 0, 3, 1'b0);
    send_beat(5, 3, 0, 0, 4, 1'b0);
    send_beat(8, 7, 0, 0, 5, 1'b0);
    expect_image("t1", 0, 1'b1, 64'h0450_6283_5604_8E05);

    // Early close
    send_beat(0, 2, 1, 2, 0, 1'b0);
    send_beat(2, 3, 1, 2, 0, 1'b1);
    expect_image("t2", 1, 1'b1, 64'h0450_2650_F000_F000);

    // Backpressure with a beat held on the input
    send_beat(4, 1, 2, 0, 9'h1C5, 1'b1);
    held_img = bus.out_image;
    check_eq("t3_img0", held_img, 64'h4285_F000_F000_F000);
    @(negedge clock);
    bus.in_valid  = 1'b1;
    bus.in_opcode = 4'd0;
    bus.in_ra     = 3'd2;
    bus.in_rb     = 3'd1;
    bus.in_rc     = 3'd2;
    bus.in_last   = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check_eq("t3_stall", {bus.in_ready, bus.out_valid, bus.out_image[61:0]},
               {1'b0, 1'b1, held_img[61:0]});
    end
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    check_eq("t3_fill", {63'd0, bus.in_ready}, 64'd1);
    m_words.delete();
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    m_words.push_back(ref_encode(0, 2, 1, 2, 0));
    send_beat(8, 0, 0, 0, 9'h1FF, 1'b1);
    expect_image("t3", 0, 1'b1, 64'h0450_81FF_F000_F000);

    // Illegal opcode in slot 1
    t4_exp = c_OPCHECK ? 64'h0450_F000_6283_F000 : 64'h0450_3298_6283_F000;
    send_beat(0, 2, 1, 2, 0, 1'b0);
    send_beat(3, 1, 2, 3, 0, 1'b0);
    send_beat(6, 1, 2, 0, 3, 1'b1);
    expect_image("t4", 0, 1'b1, t4_exp);
    send_beat(8, 7, 0, 0, 5, 1'b1);
    expect_image("t4b", 0, 1'b1, 64'h8E05_F000_F000_F000);

    // Reset mid-fill
    send_beat(6, 1, 2, 0, 3, 1'b0);
    send_beat(5, 3, 0, 0, 4, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("t5_rst", {bus.in_ready, bus.out_valid, bus.err_illegal, bus.out_count},
             {1'b1, 1'b0, 1'b0, 3'd0});
    check_eq("t5_img", bus.out_image, {4{c_PAD}});
    m_words.delete();
    m_err = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    send_beat(2, 3, 1, 2, 0, 1'b1);
    expect_image("t5", 0, 1'b1, 64'h2650_F000_F000_F000);

    // Randomized images
    for (int img = 0; img < 25; img++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        int op;
        bit last;
        case ($urandom_range(0, 6))
          0: op = 0;
          1: op = 2;
          2: op = 4;
          3: op = 5;
          4: op = 6;
          5: op = 8;
          default: op = $urandom_range(0, 15);
        endcase
        last = (i == n - 1) && ((n < 4) || ($urandom_range(0, 1) == 1));
        send_beat(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 511), last);
      end
      expect_image("rand", $urandom_range(0, 3), 1'b0, 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/risc18_program_packer.md
# risc18_program_packer

Front-end program builder for the RISC18 core. Accepts decoded instruction fields one at a time over a valid/ready stream, encodes each into the core's 16-bit instruction format, and packs four of them into the 64-bit program image that the core loads on its reset (slot 0 in bits [63:48]). It is the write side of the core's `PCin` program interface: the core consumes images, and this block produces them.

## Interface
Parameters:
- `PAD_WORD`, default 16'hF000: filler for unused slots and replacement for illegal opcodes. Opcode 4'hF falls into the core's default path, which only advances the PC.

Ports:
- `clock`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `in_valid`  in  1  instruction beat offered.
- `in_ready`  out  1  block can accept a beat.
- `in_opcode`  in  4  RISC18 opcode: ADD 0000, NDU 0010, LW 0100, SW 0101, BEQ 0110, JAL 1000.
- `in_ra`  in  3  field A.
- `in_rb`  in  3  field B.
- `in_rc`  in  3  field C, used by ADD and NDU only.
- `in_imm`  in  9  immediate. LW, SW and BEQ use [5:0]; JAL uses [8:0].
- `in_last`  in  1  this beat closes the image early.
- `out_valid`  out  1  image available.
- `out_ready`  in  1  consumer takes the image.
- `out_image`  out  64  packed program, slot0 in [63:48] through slot3 in [15:0].
- `out_count`  out  3  number of real instructions in the image, 1..4.
- `err_illegal`  out  1  sticky; an illegal opcode was seen.

## Operation
Encoding, by opcode:
- ADD and NDU: {op, ra, rb, rc, 3'b000}.
- LW, SW and BEQ: {op, ra, rb, imm[5:0]}. imm[8:6] is ignored.
- JAL: {op, ra, imm[8:0]}.

FSM has two states:
- **FILL**
  - `in_ready` = 1, `out_valid` = 0.
  - An accepted beat (`in_valid` && `in_ready` at a rising edge) writes the encoded word into slot `idx`, then `idx` increments.
  - Transition to EMIT when `idx` was 3, or when `in_last` = 1. `out_count` = `idx`+1 at that beat.
  - Slots not written keep `PAD_WORD`.
- **EMIT**
  - `in_ready` = 0, `out_valid` = 1.
  - `out_image` and `out_count` are held stable.
  - On `out_valid` && `out_ready`: go to FILL, `idx` ← 0, all slots ← `PAD_WORD`, `out_count` ← 0.

Rules:
- `in_*` is sampled only on accepted beats. `in_last` on the 4th beat behaves the same as without it.
- No empty image is possible: `in_last` always arrives with an instruction.
- Beats offered during EMIT are not accepted. The producer must hold them, per the standard valid/ready rule.

## Timing
Reset values (asynchronous, apply immediately):
- state FILL, `idx` 0.
- `in_ready` 1, `out_valid` 0.
- `out_image` {4{`PAD_WORD`}}, `out_count` 0, `err_illegal` 0.

Latency and throughput:
- `out_valid` rises the cycle after the closing beat is accepted.
- Minimum period per full image is 5 cycles (4 fill + 1 emit), with `out_ready` held at 1.
- `in_ready` is a registered state decode. There is no combinational path from `out_ready` to `in_ready`.

Boundary conditions:
- Reset mid-fill discards the partial image.
- Reset during EMIT drops the image even if `out_ready` = 1 in the same cycle.
- `idx` never wraps past 3; the closing beat always forces EMIT.

## Configuration
Macro `RISC18_PACK_OPCHECK_EN`:
- **Defined:** an opcode outside the six legal values is still accepted and consumes a slot. The slot is written with `PAD_WORD`, and `err_illegal` sets and stays set until reset.
- **Undefined:** opcodes are packed raw using the ADD field layout, and `err_illegal` is tied to 0.

## Structure
- Package `risc18_pkg` holds:
  - the opcode localparams (ADD, NDU, LW, SW, BEQ, JAL);
  - the default `PAD_WORD`;
  - the FSM state enum;
  - a function `risc18_legal(op)`.
- One sub-module, `risc18_insn_encoder`. It is combinational: fields in, 16-bit word and legal flag out. The packer instantiates it once.

## Test plan
1. **Full image.** Stimulus, four beats:
   - ADD ra2 rb1 rc2 → 0x0450
   - BEQ ra1 rb2 imm3 → 0x6283
   - SW ra3 rb0 imm4 → 0x5604
   - JAL ra7 imm5 → 0x8E05

   Required: `out_image` = 0x0450_6283_5604_8E05, `out_count` = 4, `out_valid` asserted the cycle after beat 4.
2. **Early close.** ADD 0x0450, then NDU ra3 rb1 rc2 with `in_last` → `out_image` = 0x0450_2650_F000_F000, `out_count` = 2.
3. **Backpressure.** Hold `out_ready` = 0 for 10 cycles with `in_valid` = 1 → `in_ready` = 0 and `out_image` is stable throughout. Release → one handshake, then FILL with `in_ready` = 1.
4. **Illegal opcode.** Opcode 4'h3 in slot 1, with `RISC18_PACK_OPCHECK_EN` defined → slot 1 = 0xF000, `err_illegal` = 1 and stays set across the next image. Without the macro, slot 1 holds the raw encoding and `err_illegal` = 0.
5. **Reset mid-fill.** Assert reset after 2 beats → next image starts at slot 0, holds no stale words, and `out_count` reflects only post-reset beats.
6. **Immediate masking.** LW ra1 rb2 imm 9'h1C5 → 0x4285 (imm[8:6] dropped). JAL imm 9'h1FF, ra0 → 0x81FF.
